// File: rtl/bitcoin_block_loader_if.sv
// Word stream from the block loader to a hash core: one 32-bit schedule word per
// transfer, tagged with its position in the block and the nonce.
interface bitcoin_block_loader_if;
  logic        blk_valid;
  logic        blk_ready;
  logic [31:0] blk_word;
  logic [3:0]  blk_idx;
  logic        blk_sel;
  logic [3:0]  blk_nonce;
  logic        blk_last;

  modport master (
    output blk_valid, blk_word, blk_idx, blk_sel, blk_nonce, blk_last,
    input  blk_ready
  );

  modport slave (
    input  blk_valid, blk_word, blk_idx, blk_sel, blk_nonce, blk_last,
    output blk_ready
  );
endinterface

// File: rtl/bitcoin_block_loader.sv
// Reads a 20-word block header from memory, then streams block 1 once and one
// padded block 2 per nonce to a hash core over a valid/ready word interface.
module bitcoin_block_loader #(
  parameter int NUM_NONCES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [15:0]                   message_addr,
  output logic                          mem_clk,
  output logic                          mem_we,
  output logic [15:0]                   mem_addr,
  input  logic [31:0]                   mem_read_data,
  bitcoin_block_loader_if.master        blk,
  output logic                          done
);

  localparam logic [3:0] LAST_NONCE = 4'(NUM_NONCES - 1);
  localparam logic [3:0] LAST_IDX   = 4'd15;
  localparam logic [4:0] LAST_ISSUE = 5'd19;
  localparam logic [4:0] FIRST_CAP  = 5'd2;
  localparam logic [4:0] FETCH_END  = 5'd21;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT1,
    EMIT2,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cyc;
  logic [4:0]  cap_idx;
  logic [3:0]  idx;
  logic [3:0]  nonce;
  logic [31:0] msg [0:19];
  logic        emit_active;
  logic        xfer;

  // Block 2 layout: header tail, nonce in place of word 19, then SHA-256 padding
  // for a 640-bit message.
  function automatic logic [31:0] block2_word(
    input logic [3:0]  i,
    input logic [3:0]  n,
    input logic [31:0] m16,
    input logic [31:0] m17,
    input logic [31:0] m18
  );
    logic [31:0] w;
    case (i)
      4'd0:    w = m16;
      4'd1:    w = m17;
      4'd2:    w = m18;
      4'd3:    w = {28'd0, n};
      4'd4:    w = 32'h8000_0000;
      4'd15:   w = 32'h0000_0280;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign mem_clk     = clk;
  assign mem_we      = 1'b0;
  assign emit_active = (state == EMIT1) || (state == EMIT2);
  assign xfer        = emit_active && blk.blk_ready;
  assign cap_idx     = cyc - FIRST_CAP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    blk.blk_valid = 1'b0;
    blk.blk_word  = 32'd0;
    blk.blk_idx   = idx;
    blk.blk_sel   = 1'b0;
    blk.blk_nonce = nonce;
    blk.blk_last  = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (cyc == FETCH_END) state_next = EMIT1;
      end
      EMIT1: begin
        blk.blk_valid = 1'b1;
        blk.blk_word  = msg[idx];
        if (xfer && idx == LAST_IDX) state_next = EMIT2;
      end
      EMIT2: begin
        blk.blk_valid = 1'b1;
        blk.blk_sel   = 1'b1;
        blk.blk_word  = block2_word(idx, nonce, msg[16], msg[17], msg[18]);
        blk.blk_last  = (idx == LAST_IDX) && (nonce == LAST_NONCE);
        if (xfer && idx == LAST_IDX && nonce == LAST_NONCE) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read issue runs one address per cycle from the accept edge; with two-cycle
  // memory latency, edge number cyc captures the word issued at edge cyc-2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc      <= 5'd0;
      idx      <= 4'd0;
      nonce    <= 4'd0;
      mem_addr <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cyc      <= 5'd1;
            mem_addr <= message_addr;
          end
        end
        FETCH: begin
          cyc <= cyc + 5'd1;
          if (cyc <= LAST_ISSUE) mem_addr <= mem_addr + 16'd1;
          if (cyc == FETCH_END) begin
            idx   <= 4'd0;
            nonce <= 4'd0;
          end
        end
        EMIT1: begin
          if (xfer) idx <= idx + 4'd1;
        end
        EMIT2: begin
          if (xfer) begin
            idx <= idx + 4'd1;
            if (idx == LAST_IDX && nonce != LAST_NONCE) nonce <= nonce + 4'd1;
          end
        end
        FINISH: begin
          idx   <= 4'd0;
          nonce <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && cyc >= FIRST_CAP) msg[cap_idx] <= mem_read_data;
  end

endmodule
